// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory access unit.
// Loads and buffered-store drains share a variable-latency req/ack bus with at
// most one transaction outstanding. Stores retire into a SB_DEPTH-entry FIFO
// store buffer and drain in the background.
// Optional feature macro DMEM_STORE_FWD_EN: when defined, loads that hit the
// store buffer are served from the youngest matching entry and missing loads
// bypass buffered stores. When undefined, every load waits for an empty
// buffer and no address comparators exist.
//
// Handshake: the MEM stage holds req_* stable while mem_stall_c=1; a request
// is consumed in a cycle with req_valid=1 and mem_stall_c=0. On the bus side,
// dm_req/dm_we/dm_addr/dm_wdata are registered and held until the cycle in
// which dm_ack=1 (ack may arrive in the first request cycle).
`timescale 1ns/1ps
module dmem_access_unit #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int SB_DEPTH     = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            req_valid,
  input  logic                            req_we,
  input  logic [ADDRESS_SIZE-1:0]         req_addr,
  input  logic [DATA_SIZE-1:0]            req_wdata,
  input  logic [4:0]                      req_dest,
  output logic                            mem_stall_c,
  output logic                            resp_valid,
  output logic [DATA_SIZE-1:0]            resp_data,
  output logic [4:0]                      resp_dest,
  output logic [$clog2(SB_DEPTH+1)-1:0]   sb_count,
  output logic                            sb_empty,
  output logic                            dm_req,
  output logic                            dm_we,
  output logic [ADDRESS_SIZE-1:0]         dm_addr,
  output logic [DATA_SIZE-1:0]            dm_wdata,
  input  logic                            dm_ack,
  input  logic [DATA_SIZE-1:0]            dm_rdata
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_BUS  = 2'd1,
    ST_DRAIN_BUS = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                    load_req, store_req, sb_full;
  logic                    push, pop, fwd_take, load_ack, load_go;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [ADDRESS_SIZE-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_SIZE-1:0]    sb_data_q [SB_DEPTH];

  logic                    dm_req_q, dm_we_q;
  logic [ADDRESS_SIZE-1:0] dm_addr_q;
  logic [DATA_SIZE-1:0]    dm_wdata_q;
  logic                    resp_valid_q;
  logic [DATA_SIZE-1:0]    resp_data_q;
  logic [4:0]              resp_dest_q;

  logic                    fwd_hit;
  logic [DATA_SIZE-1:0]    fwd_data;

  assign load_req  = req_valid & ~req_we;
  assign store_req = req_valid & req_we;
  // Fullness uses the count at cycle start, so a same-cycle pop frees nothing.
  assign sb_full   = (count_q == CW'(SB_DEPTH));

`ifdef DMEM_STORE_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (sb_addr_q[fwd_idx] == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[fwd_idx];
      end
    end
  end

  // A missing load bypasses buffered stores.
  assign load_go = load_req & ~fwd_hit;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  // Without forwarding a load may only use the bus once the buffer is empty.
  assign load_go  = load_req & (count_q == '0);
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: loads take priority over drains when leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_go)              state_d = ST_LOAD_BUS;
        else if (count_q != '0)   state_d = ST_DRAIN_BUS;
      end
      ST_LOAD_BUS:  if (dm_ack) state_d = ST_IDLE;
      ST_DRAIN_BUS: if (dm_ack) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: buffer push/pop, forwarding and load completion, stall.
  always_comb begin
    push        = store_req & ~sb_full;
    pop         = (state_q == ST_DRAIN_BUS) & dm_ack;
    fwd_take    = load_req & (state_q == ST_IDLE) & fwd_hit;
    load_ack    = load_req & (state_q == ST_LOAD_BUS) & dm_ack;
    mem_stall_c = req_valid & ~(push | fwd_take | load_ack);
  end

  // Bus request registers: loaded on the IDLE decision, dropped on ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
    end else if (state_q == ST_IDLE && state_d == ST_LOAD_BUS) begin
      dm_req_q  <= 1'b1;
      dm_we_q   <= 1'b0;
      dm_addr_q <= req_addr;
    end else if (state_q == ST_IDLE && state_d == ST_DRAIN_BUS) begin
      dm_req_q   <= 1'b1;
      dm_we_q    <= 1'b1;
      dm_addr_q  <= sb_addr_q[rd_ptr_q];
      dm_wdata_q <= sb_data_q[rd_ptr_q];
    end else if (dm_req_q && dm_ack) begin
      dm_req_q <= 1'b0;
      dm_we_q  <= 1'b0;
    end
  end

  // Store buffer FIFO: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        sb_addr_q[wr_ptr_q] <= req_addr;
        sb_data_q[wr_ptr_q] <= req_wdata;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Load response: one-cycle valid pulse, data and tag hold between loads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_dest_q  <= '0;
    end else begin
      resp_valid_q <= load_ack | fwd_take;
      if (load_ack) begin
        resp_data_q <= dm_rdata;
        resp_dest_q <= req_dest;
      end else if (fwd_take) begin
        resp_data_q <= fwd_data;
        resp_dest_q <= req_dest;
      end
    end
  end

  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_dest  = resp_dest_q;
  assign sb_count   = count_q;
  assign sb_empty   = (count_q == '0) && (state_q != ST_DRAIN_BUS);

endmodule
